// File: rtl/counter_pkg.sv
// Shared mode and FSM state encodings for the mode_counter block.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the last count as a tick.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic slowclk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge slowclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mode_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot modes.
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             slowclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] sw_out,
  output logic             tc,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, term, stepped;
  logic             tc_q, tc_d, step;

  // HALT freezes the prescaler by withholding its enable.
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .slowclk (slowclk),
    .rst_n   (rst_n),
    .en      (en && (state_q == ST_RUN)),
    .clr     (load),
    .tick    (step)
  );

  always_comb begin
    term    = dir ? '1 : '0;
    stepped = dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
    cnt_d   = cnt_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = sw_in;
      state_d = ST_RUN;
    end else if (step) begin
      case (mode_e'(mode))
        MODE_SAT: begin
          if (cnt_q != term) begin
            cnt_d = stepped;
            tc_d  = (stepped == term);
          end
        end
        MODE_ONESHOT: begin
          cnt_d = stepped;
          tc_d  = (stepped == term);
          if (stepped == term) state_d = ST_HALT;
        end
        default: begin
          cnt_d = stepped;
          tc_d  = (stepped == term);
        end
      endcase
    end
  end

  always_ff @(posedge slowclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign sw_out = cnt_q;
  assign tc     = tc_q;
  assign done   = (state_q == ST_HALT);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: vector table on PRESCALE=1 plus multi-cycle sequences.
module tb_mode_counter;

  logic       slowclk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] sw_in   = '0;
  logic       load    = 1'b0;
  logic       en      = 1'b0;
  logic       dir     = 1'b1;
  logic [1:0] mode    = 2'b00;

  logic [7:0] out1, out4, out5;
  logic       tc1, tc4, tc5, done1, done4, done5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 slowclk = ~slowclk;

  mode_counter #(.WIDTH(8), .PRESCALE(1)) d1 (
    .slowclk(slowclk), .rst_n(rst_n), .sw_in(sw_in), .load(load), .en(en),
    .dir(dir), .mode(mode), .sw_out(out1), .tc(tc1), .done(done1));
  mode_counter #(.WIDTH(8), .PRESCALE(4)) d4 (
    .slowclk(slowclk), .rst_n(rst_n), .sw_in(sw_in), .load(load), .en(en),
    .dir(dir), .mode(mode), .sw_out(out4), .tc(tc4), .done(done4));
  mode_counter #(.WIDTH(8), .PRESCALE(5)) d5 (
    .slowclk(slowclk), .rst_n(rst_n), .sw_in(sw_in), .load(load), .en(en),
    .dir(dir), .mode(mode), .sw_out(out5), .tc(tc5), .done(done5));

  typedef struct {
    logic       ld;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_tc;
    logic       exp_done;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge slowclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Inputs are changed 1 time unit after a rising edge; outputs sampled at the same point.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'd10,  8'd10,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'd100, 8'd100, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd0,   8'd101, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'd0,   8'd101, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   8'd100, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'd255, 8'd255, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   8'd255, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd1,   8'd1,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   8'd0,   1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'd0,   8'd1,   1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'd254, 8'd254, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'd0,   8'd255, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'd0,   8'd255, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'd0,   8'd254, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 2'd3, 8'd0,   8'd255, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 2'd3, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd253, 8'd253, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd0,   8'd254, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd0,   8'd255, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   8'd255, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd7,   8'd7,   1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 2'd2, 8'd0,   8'd6,   1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd255, 8'd255, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd0,   8'd0,   1'b0, 1'b0};

    // Reset state of every instance.
    #1;
    check("rst_out1", 32'(out1), 0);  check("rst_tc1", 32'(tc1), 0);  check("rst_done1", 32'(done1), 0);
    check("rst_out4", 32'(out4), 0);  check("rst_tc4", 32'(tc4), 0);  check("rst_done4", 32'(done4), 0);
    check("rst_out5", 32'(out5), 0);  check("rst_tc5", 32'(tc5), 0);  check("rst_done5", 32'(done5), 0);

    // Free-running wrap count on PRESCALE=1: 0..255 then back to 0.
    en = 1'b1; dir = 1'b1; mode = 2'd0; load = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      check("wrap_out", 32'(out1), 32'(k % 256));
      check("wrap_tc", 32'(tc1), (k == 255) ? 1 : 0);
    end

    // Vector table on the PRESCALE=1 instance.
    for (int unsigned i = 0; i < 26; i++) begin
      load = vecs[i].ld; en = vecs[i].en; dir = vecs[i].dir;
      mode = vecs[i].mode; sw_in = vecs[i].din;
      tick();
      check($sformatf("vec%0d_out", i), 32'(out1), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_tc", i), 32'(tc1), 32'(vecs[i].exp_tc));
      check($sformatf("vec%0d_done", i), 32'(done1), 32'(vecs[i].exp_done));
    end

    // Saturating down-count with PRESCALE=4 from a load of 3.
    load = 1'b0; do_reset();
    tick();
    load = 1'b1; sw_in = 8'd3; dir = 1'b0; mode = 2'd1; en = 1'b1;
    tick();
    check("sat4_load", 32'(out4), 3);
    load = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("sat4_out", 32'(out4), (k <= 12) ? 32'(3 - k / 4) : 0);
      check("sat4_tc", 32'(tc4), (k == 12) ? 1 : 0);
    end

    // One-shot from 250 on PRESCALE=1: halts at 255 and stays there.
    load = 1'b1; sw_in = 8'd250; dir = 1'b1; mode = 2'd2;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("os_out", 32'(out1), 32'(250 + k));
      check("os_tc", 32'(tc1), (k == 5) ? 1 : 0);
    end
    check("os_done", 32'(done1), 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("os_hold", 32'(out1), 255);
      check("os_hold_tc", 32'(tc1), 0);
    end
    load = 1'b1; sw_in = 8'd7;
    tick();
    load = 1'b0; en = 1'b0;
    check("os_reload", 32'(out1), 7);
    check("os_reload_done", 32'(done1), 0);

    // Asynchronous reset mid-prescale (PRESCALE=4 at count 2), then restart timing.
    load = 1'b1; sw_in = 8'd50; mode = 2'd0; dir = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    check("mid_pre_out", 32'(out4), 50);
    #2 rst_n = 1'b0;
    #1;
    check("async_out4", 32'(out4), 0);
    check("async_tc4", 32'(tc4), 0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("post_rst_out4", 32'(out4), (k == 4) ? 1 : 0);
    end

    // Asynchronous reset while halted (PRESCALE=1).
    load = 1'b1; sw_in = 8'd254; mode = 2'd2; dir = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("halt_pre_done", 32'(done1), 1);
    check("halt_pre_out", 32'(out1), 255);
    #2 rst_n = 1'b0;
    #1;
    check("halt_rst_done", 32'(done1), 0);
    check("halt_rst_out", 32'(out1), 0);
    check("halt_rst_tc", 32'(tc1), 0);
    #1 rst_n = 1'b1;
    mode = 2'd0;
    tick();
    check("halt_rst_resume", 32'(out1), 1);

    // Enable gap on PRESCALE=5 delays the step by exactly the gap length.
    en = 1'b0; do_reset();
    tick();
    en = 1'b1; dir = 1'b1; mode = 2'd0;
    tick(); tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("gap_hold5", 32'(out5), 0);
    end
    en = 1'b1;
    tick(); tick();
    check("gap_pre5", 32'(out5), 0);
    tick();
    check("gap_step5", 32'(out5), 1);
    check("gap_tc5", 32'(tc5), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
